block_ram: RTL and testbench

Single-port synchronous on-chip memory with a level-based request/ready handshake. It is the working store used by the graph engine for distance, visited and adjacency data. Reads and writes share one address bus and are served one at a time. Each request is acknowledged by a ready flag that stays high until the requester drops its enable.

---
 rtl/block_ram_pkg.sv | 9 +
 rtl/block_ram_core.sv | 44 ++++
 rtl/block_ram.sv | 136 +++++++++++++
 tb/tb_block_ram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/block_ram_pkg.sv
// Shared memory-client constants for the graph engine working store.
// Every memory client takes its default address/data widths from here so the
// whole engine agrees on one bus shape.
package block_ram_pkg;

  localparam int unsigned DEFAULT_MADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_MDATA_WIDTH = 16;

endpackage : block_ram_pkg

// File: rtl/block_ram_core.sv
// Plain inferable single-port RAM array: synchronous write, synchronous
// registered read. The read register is cleared by reset; the array is not.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset (read reg only)
//   i_we, i_wdata : write enable and data, written at the edge
//   i_re          : load the read register from the array at the edge
//   i_addr        : word index shared by read and write
//   o_rdata       : registered read word, held between reads
module block_ram_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array write port; kept reset-free so it maps onto a RAM macro.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read port; holds its value until the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : block_ram_core

// File: rtl/block_ram.sv
// Single-port working store with a level request/ready handshake.
// One request is served at a time; a write beats a simultaneous read.
// Ports:
//   reset            : synchronous active-high reset
//   clock            : rising-edge clock
//   mem_read_enable  : read request (level)
//   mem_write_enable : write request (level)
//   mem_write_ready  : write done, held while write request held
//   mem_read_ready   : read data valid, held while read request held
//   mem_addr         : word address (upper bits beyond depth ignored)
//   mem_read_data    : read result
//   mem_write_data   : write data
module block_ram
  import block_ram_pkg::*;
#(
  parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = 1024
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   mem_read_enable,
  input  logic                   mem_write_enable,
  output logic                   mem_write_ready,
  output logic                   mem_read_ready,
  input  logic [MADDR_WIDTH-1:0] mem_addr,
  output logic [MDATA_WIDTH-1:0] mem_read_data,
  input  logic [MDATA_WIDTH-1:0] mem_write_data
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE_ACK = 2'd1,
    S_READ_WAIT = 2'd2,
    S_READ_ACK  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_write_ready;
  logic             r_read_ready;
  logic [IDX_W-1:0] r_idx;
  logic             w_we;
  logic             w_re;
  logic             w_core_we;
  logic             w_core_re;
  logic [IDX_W-1:0] w_in_idx;
  logic [IDX_W-1:0] w_core_addr;

  // Only a clean 1 requests; X/Z on an enable counts as idle.
  assign w_we = (mem_write_enable === 1'b1);
  assign w_re = (mem_read_enable === 1'b1);

  assign w_in_idx = mem_addr[IDX_W-1:0];

  // Address bits above the depth wrap and are intentionally dropped.
  generate
    if (MADDR_WIDTH > IDX_W) begin : g_unused_addr
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^mem_addr[MADDR_WIDTH-1:IDX_W];
    end
  endgenerate

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_we) begin
          w_next = S_WRITE_ACK;
        end else if (w_re) begin
          w_next = S_READ_WAIT;
        end
      end
      S_WRITE_ACK: begin
        if (!w_we) begin
          w_next = S_IDLE;
        end
      end
      S_READ_WAIT: begin
        w_next = S_READ_ACK;
      end
      S_READ_ACK: begin
        if (!w_re) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, registered ready flags and the latched read index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_write_ready <= 1'b0;
      r_read_ready  <= 1'b0;
      r_idx         <= '0;
    end else begin
      r_state       <= w_next;
      r_write_ready <= (w_next == S_WRITE_ACK);
      r_read_ready  <= (w_next == S_READ_ACK);
      if ((r_state == S_IDLE) && (w_next == S_READ_WAIT)) begin
        r_idx <= w_in_idx;
      end
    end
  end

  // The write happens at the accepting edge; the array read happens on the
  // READ_WAIT edge from the latched index, landing in the core's read register.
  assign w_core_we   = (r_state == S_IDLE) && w_we && !reset;
  assign w_core_re   = (r_state == S_READ_WAIT);
  assign w_core_addr = (r_state == S_IDLE) ? w_in_idx : r_idx;

  block_ram_core #(
    .DATA_W (MDATA_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_W)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_core_we),
    .i_re    (w_core_re),
    .i_addr  (w_core_addr),
    .i_wdata (mem_write_data),
    .o_rdata (mem_read_data)
  );

  assign mem_write_ready = r_write_ready;
  assign mem_read_ready  = r_read_ready;

endmodule : block_ram

// File: tb/tb_block_ram.sv
// Self-checking bench for block_ram against an array model of the store.
module tb_block_ram;
  import block_ram_pkg::*;

  localparam int unsigned MAW   = DEFAULT_MADDR_WIDTH;
  localparam int unsigned MDW   = DEFAULT_MDATA_WIDTH;
  localparam int unsigned DEPTH = 1024;

  logic           reset;
  logic           clock;
  logic           mem_read_enable;
  logic           mem_write_enable;
  logic           mem_write_ready;
  logic           mem_read_ready;
  logic [MAW-1:0] mem_addr;
  logic [MDW-1:0] mem_read_data;
  logic [MDW-1:0] mem_write_data;

  logic [MDW-1:0] model [DEPTH];
  int n_checks;
  int n_errors;

  block_ram #(
    .MADDR_WIDTH (MAW),
    .MDATA_WIDTH (MDW),
    .MEM_DEPTH   (DEPTH)
  ) dut (
    .reset            (reset),
    .clock            (clock),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_ready  (mem_write_ready),
    .mem_read_ready   (mem_read_ready),
    .mem_addr         (mem_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_data   (mem_write_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return at the falling edge for driving/sampling.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic int unsigned widx(input logic [MAW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic do_write(input logic [MAW-1:0] a, input logic [MDW-1:0] d);
    mem_write_enable = 1'b1;
    mem_addr         = a;
    mem_write_data   = d;
    step();
    model[widx(a)] = d;
    check("wr_ready_hi", 32'(mem_write_ready), 32'd1);
    check("wr_rd_ready_lo", 32'(mem_read_ready), 32'd0);
    mem_write_enable = 1'b0;
    mem_addr         = MAW'($urandom);
    mem_write_data   = MDW'($urandom);
    step();
    check("wr_ready_fall", 32'(mem_write_ready), 32'd0);
  endtask

  task automatic do_read(input logic [MAW-1:0] a);
    logic [MDW-1:0] exp;
    exp = model[widx(a)];
    mem_read_enable = 1'b1;
    mem_addr        = a;
    check("rd_ready_at_req", 32'(mem_read_ready), 32'd0);
    step();
    check("rd_wait_lo", 32'(mem_read_ready), 32'd0);
    mem_addr = MAW'($urandom);
    step();
    check("rd_ready_hi", 32'(mem_read_ready), 32'd1);
    check("rd_data", 32'(mem_read_data), 32'(exp));
    step();
    check("rd_hold_ready", 32'(mem_read_ready), 32'd1);
    check("rd_hold_data", 32'(mem_read_data), 32'(exp));
    mem_read_enable = 1'b0;
    step();
    check("rd_ready_fall", 32'(mem_read_ready), 32'd0);
  endtask

  initial begin
    logic [MDW-1:0] d;
    logic [MDW-1:0] d2;
    logic [MAW-1:0] a;
    n_checks = 0;
    n_errors = 0;
    reset            = 1'b1;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;

    // Reset held for two edges with a read request pending.
    mem_read_enable = 1'b1;
    step();
    step();
    check("rst_wr_ready", 32'(mem_write_ready), 32'd0);
    check("rst_rd_ready", 32'(mem_read_ready), 32'd0);
    check("rst_rd_data", 32'(mem_read_data), 32'd0);
    mem_read_enable = 1'b0;
    reset = 1'b0;
    step();
    check("post_rst_idle", 32'(mem_read_ready), 32'd0);

    // Write/read loop at i*MADDR_WIDTH/8.
    for (int i = 3; i <= 15; i++) begin
      a = MAW'(i * MAW / 8);
      do_write(a, MDW'($urandom));
      do_read(a);
    end

    // Write request held for five edges: one write, ready throughout.
    d  = MDW'($urandom);
    d2 = ~d;
    mem_write_enable = 1'b1;
    mem_addr         = MAW'(40);
    mem_write_data   = d;
    model[40] = d;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_wr_ready", 32'(mem_write_ready), 32'd1);
      mem_write_data = d2;
    end
    mem_write_enable = 1'b0;
    step();
    check("hold_wr_fall", 32'(mem_write_ready), 32'd0);
    do_read(MAW'(40));

    // Address wrap.
    do_write(MAW'(5), 16'h1234);
    do_write(MAW'(5 + DEPTH), 16'hBEEF);
    check("wrap_model", 32'(model[5]), 32'hBEEF);
    do_read(MAW'(5));

    // Simultaneous write and read: write first, then the read sees new data.
    d = MDW'($urandom);
    mem_write_enable = 1'b1;
    mem_read_enable  = 1'b1;
    mem_addr         = MAW'(77);
    mem_write_data   = d;
    step();
    model[77] = d;
    check("both_wr_ready", 32'(mem_write_ready), 32'd1);
    check("both_rd_ready", 32'(mem_read_ready), 32'd0);
    mem_write_enable = 1'b0;
    step();
    check("both_idle_wr", 32'(mem_write_ready), 32'd0);
    check("both_idle_rd", 32'(mem_read_ready), 32'd0);
    step();
    check("both_rd_wait", 32'(mem_read_ready), 32'd0);
    step();
    check("both_rd_ready_hi", 32'(mem_read_ready), 32'd1);
    check("both_rd_data", 32'(mem_read_data), 32'(d));
    mem_read_enable = 1'b0;
    step();
    check("both_rd_fall", 32'(mem_read_ready), 32'd0);

    // Reset during READ_WAIT aborts the read.
    mem_read_enable = 1'b1;
    mem_addr        = MAW'(6);
    step();
    reset = 1'b1;
    step();
    check("abort_rd_ready", 32'(mem_read_ready), 32'd0);
    check("abort_rd_data", 32'(mem_read_data), 32'd0);
    // Write request during reset must not reach the array.
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b1;
    mem_addr         = MAW'(40);
    mem_write_data   = ~model[40];
    step();
    check("abort_rd_ready2", 32'(mem_read_ready), 32'd0);
    check("rst_wr_ignored", 32'(mem_write_ready), 32'd0);
    mem_write_enable = 1'b0;
    reset = 1'b0;
    step();
    do_read(MAW'(40));
    do_read(MAW'(14 * MAW / 8));

    // Randomised mix over a small window, addresses aliased by DEPTH.
    for (int i = 0; i < 16; i++) do_write(MAW'(100 + i), MDW'($urandom));
    for (int n = 0; n < 40; n++) begin
      a = MAW'(100 + $urandom_range(0, 15) + DEPTH * $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) do_write(a, MDW'($urandom));
      else do_read(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_block_ram
